bsort_main: RTL and testbench

- Self-contained bubble-sort accelerator, top-level kernel of the bsort100 benchmark.
- Holds an internal array of NUM_ELEMS signed 32-bit words in a dual-port RAM, starting at byte address MEM_BASE.
- On a start pulse it sorts the array ascending, then pulses done.
- A two-channel slave memory port lets a host read and write the array while the engine is idle.

---
 rtl/bsort_pkg.sv | 11 +
 rtl/bsort_dpram.sv | 27 ++
 rtl/bsort_main.sv | 168 ++++++++++++++++
 tb/tb_bsort_main.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bsort_pkg.sv
// Shared types and widths for the bsort_main bubble-sort accelerator.
package bsort_pkg;
  localparam int WORD_W  = 32;
  localparam int LANE_AW = 7;
  localparam int LANE_DW = 64;
  localparam int NUM_CH  = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_PASS_START, S_READ, S_CMP, S_PASS_END, S_DONE
  } state_t;
endpackage

// File: rtl/bsort_dpram.sv
// Dual-port word RAM, synchronous read-first, independent write enables.
module bsort_dpram
  import bsort_pkg::*;
#(
  parameter int DEPTH = 100,
  parameter int AW    = 7
) (
  input  logic              clock,
  input  logic              we_a,
  input  logic [AW-1:0]     addr_a,
  input  logic [WORD_W-1:0] d_a,
  output logic [WORD_W-1:0] q_a,
  input  logic              we_b,
  input  logic [AW-1:0]     addr_b,
  input  logic [WORD_W-1:0] d_b,
  output logic [WORD_W-1:0] q_b
);
  logic [WORD_W-1:0] mem [DEPTH];

  // Port b is written last so it wins a same-address collision.
  always_ff @(posedge clock) begin
    if (we_a) mem[addr_a] <= d_a;
    if (we_b) mem[addr_b] <= d_b;
    q_a <= mem[addr_a];
    q_b <= mem[addr_b];
  end
endmodule

// File: rtl/bsort_main.sv
// Bubble-sort engine over an internal RAM with a two-channel host port.
// Define SORT_EARLY_EXIT_EN to stop after the first pass without a swap.
module bsort_main
  import bsort_pkg::*;
#(
  parameter int MEM_BASE  = 32,
  parameter int NUM_ELEMS = 100
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start_port,
  input  logic [NUM_CH-1:0]           S_oe_ram,
  input  logic [NUM_CH-1:0]           S_we_ram,
  input  logic [NUM_CH*LANE_AW-1:0]   S_addr_ram,
  input  logic [NUM_CH*LANE_DW-1:0]   S_Wdata_ram,
  input  logic [NUM_CH*LANE_AW-1:0]   S_data_ram_size,
  output logic                        done_port,
  output logic [NUM_CH*LANE_DW-1:0]   Sout_Rdata_ram,
  output logic [NUM_CH-1:0]           Sout_DataRdy
);
  localparam int AW = $clog2(NUM_ELEMS);
  localparam logic [AW-1:0] LAST = AW'(NUM_ELEMS - 1);

  state_t state, state_nx;
  logic [AW-1:0] j, pass;
  logic swapped, init_pending;
  logic swap, last_j, early_stop;

  logic [NUM_CH-1:0]              ok, rd_vld;
  logic [NUM_CH-1:0][AW-1:0]      s_idx;
  logic [NUM_CH-1:0][WORD_W-1:0]  q;

  logic              we_a, we_b;
  logic [AW-1:0]     addr_a, addr_b;
  logic [WORD_W-1:0] d_a, d_b;

  // Host lane decode: in-window, word-aligned, 32-bit accesses only.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    logic [LANE_AW-1:0] a, sz;
    logic [31:0]        off;
    assign a   = S_addr_ram[LANE_AW*k +: LANE_AW];
    assign sz  = S_data_ram_size[LANE_AW*k +: LANE_AW];
    assign off = 32'(a) - 32'(MEM_BASE);
    assign ok[k] = (32'(a) >= 32'(MEM_BASE)) && (off < 32'(4 * NUM_ELEMS)) &&
                   (a[1:0] == 2'b00) && (sz == LANE_AW'(WORD_W));
    assign s_idx[k] = off[AW+1:2];
    assign Sout_Rdata_ram[LANE_DW*k +: LANE_DW] =
      rd_vld[k] ? {{(LANE_DW-WORD_W){1'b0}}, q[k]} : '0;
  end

  logic unused_bits;
  assign unused_bits = ^{S_Wdata_ram[127:96], S_Wdata_ram[63:32], swapped};

  assign swap   = $signed(q[0]) > $signed(q[1]);
  assign last_j = (j == LAST - pass);

`ifdef SORT_EARLY_EXIT_EN
  assign early_stop = !(swapped || swap);
`else
  assign early_stop = 1'b0;
`endif

  bsort_dpram #(.DEPTH(NUM_ELEMS), .AW(AW)) u_ram (
    .clock  (clock),
    .we_a   (we_a),
    .addr_a (addr_a),
    .d_a    (d_a),
    .q_a    (q[0]),
    .we_b   (we_b),
    .addr_b (addr_b),
    .d_b    (d_b),
    .q_b    (q[1])
  );

  // RAM port ownership: host lanes in IDLE, engine otherwise.
  always_comb begin
    we_a   = 1'b0;
    we_b   = 1'b0;
    addr_a = s_idx[0];
    addr_b = s_idx[1];
    d_a    = S_Wdata_ram[31:0];
    d_b    = S_Wdata_ram[95:64];
    case (state)
      S_IDLE: begin
        we_a = ok[0] & S_we_ram[0];
        we_b = ok[1] & S_we_ram[1];
      end
      S_INIT: begin
        we_a   = 1'b1;
        addr_a = j;
        d_a    = 32'd0 - 32'(j) - 32'd1;
      end
      S_READ: begin
        addr_a = j;
        addr_b = j + AW'(1);
      end
      S_CMP: begin
        addr_a = j;
        addr_b = j + AW'(1);
        if (swap) begin
          we_a = 1'b1;
          we_b = 1'b1;
          d_a  = q[1];
          d_b  = q[0];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:       if (start_port) state_nx = init_pending ? S_INIT : S_PASS_START;
      S_INIT:       if (j == LAST) state_nx = S_PASS_START;
      S_PASS_START: state_nx = S_READ;
      S_READ:       state_nx = S_CMP;
      S_CMP: begin
        if (!last_j)                          state_nx = S_READ;
        else if (pass == LAST || early_stop)  state_nx = S_DONE;
        else                                  state_nx = S_PASS_START;
      end
      S_DONE:       state_nx = S_IDLE;
      default:      state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      init_pending <= 1'b1;
      j            <= '0;
      pass         <= '0;
      swapped      <= 1'b0;
      Sout_DataRdy <= '0;
      rd_vld       <= '0;
    end else begin
      Sout_DataRdy <= (state == S_IDLE) ? (ok & (S_oe_ram | S_we_ram)) : '0;
      rd_vld       <= (state == S_IDLE) ? (ok & S_oe_ram) : '0;
      case (state)
        S_IDLE: begin
          j    <= '0;
          pass <= AW'(1);
        end
        S_INIT: begin
          j <= j + AW'(1);
          if (j == LAST) init_pending <= 1'b0;
        end
        S_PASS_START: begin
          j       <= '0;
          swapped <= 1'b0;
        end
        S_CMP: begin
          if (swap) swapped <= 1'b1;
          if (last_j) pass <= pass + AW'(1);
          else        j    <= j + AW'(1);
        end
        default: ;
      endcase
    end
  end

  assign done_port = (state == S_DONE);
endmodule

// File: tb/tb_bsort_main.sv
// Directed scoreboard bench for bsort_main (small array so the 7-bit host window covers it).
module tb_bsort_main;
  localparam int N    = 20;
  localparam int BASE = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_port;
  logic [1:0]   S_oe_ram, S_we_ram;
  logic [13:0]  S_addr_ram, S_data_ram_size;
  logic [127:0] S_Wdata_ram;
  logic         done_port;
  logic [127:0] Sout_Rdata_ram;
  logic [1:0]   Sout_DataRdy;

  int checks = 0;
  int errors = 0;
  int mdl [N];

  typedef struct { int ch; logic [63:0] exp; } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  bsort_main #(.MEM_BASE(BASE), .NUM_ELEMS(N)) dut (
    .clock           (clk),
    .reset           (reset),
    .start_port      (start_port),
    .S_oe_ram        (S_oe_ram),
    .S_we_ram        (S_we_ram),
    .S_addr_ram      (S_addr_ram),
    .S_Wdata_ram     (S_Wdata_ram),
    .S_data_ram_size (S_data_ram_size),
    .done_port       (done_port),
    .Sout_Rdata_ram  (Sout_Rdata_ram),
    .Sout_DataRdy    (Sout_DataRdy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit valid(input int a, input int sz);
    return (a >= BASE) && (a < BASE + 4*N) && (a % 4 == 0) && (sz == 32);
  endfunction

  // Cycles from the start sample to DONE, excluding any init phase.
  function automatic int sort_lat();
    int v [N];
    int lat = 0;
    bit sw;
    for (int i = 0; i < N; i++) v[i] = mdl[i];
    for (int p = 1; p < N; p++) begin
      lat += 1 + 2*(N-p);
      sw = 0;
      for (int i = 0; i < N-p; i++)
        if (v[i] > v[i+1]) begin int t = v[i]; v[i] = v[i+1]; v[i+1] = t; sw = 1; end
`ifdef SORT_EARLY_EXIT_EN
      if (!sw) break;
`endif
    end
    return lat + 1;
  endfunction

  task automatic model_sort();
    for (int i = 1; i < N; i++) begin
      int t = mdl[i];
      int k = i - 1;
      while (k >= 0 && mdl[k] > t) begin mdl[k+1] = mdl[k]; k--; end
      mdl[k+1] = t;
    end
  endtask

  task automatic acc(input logic [1:0] oe, input logic [1:0] we, input int a0, input int a1,
                     input int w0, input int w1, input int sz0 = 32, input int sz1 = 32);
    int a[2], w[2], sz[2];
    logic [1:0] exp_rdy, exp_rd;
    exp_t e;
    a[0] = a0; a[1] = a1; w[0] = w0; w[1] = w1; sz[0] = sz0; sz[1] = sz1;
    @(negedge clk);
    S_oe_ram = oe; S_we_ram = we;
    S_addr_ram = {7'(a1), 7'(a0)};
    S_data_ram_size = {7'(sz1), 7'(sz0)};
    S_Wdata_ram = {32'd0, 32'(w1), 32'd0, 32'(w0)};
    for (int k = 0; k < 2; k++) begin
      exp_rdy[k] = (oe[k] | we[k]) & valid(a[k], sz[k]);
      exp_rd[k]  = oe[k] & valid(a[k], sz[k]);
      if (exp_rd[k]) sb.push_back('{k, {32'd0, 32'(mdl[(a[k]-BASE)/4])}});
    end
    for (int k = 0; k < 2; k++)
      if (we[k] && valid(a[k], sz[k])) mdl[(a[k]-BASE)/4] = w[k];
    @(negedge clk);
    S_oe_ram = 0; S_we_ram = 0;
    S_data_ram_size = {7'd32, 7'd32};
    chk("dataRdy", 64'(Sout_DataRdy), 64'(exp_rdy));
    for (int k = 0; k < 2; k++)
      if (exp_rd[k]) begin
        e = sb.pop_front();
        chk("rd_lane", 64'(e.ch), 64'(k));
        chk("rdata", Sout_Rdata_ram[64*k +: 64], e.exp);
      end
  endtask

  task automatic read_all();
    for (int i = 0; i < N; i += 2) acc(2'b11, 2'b00, BASE + 4*i, BASE + 4*(i+1), 0, 0);
  endtask

  task automatic run_sort(input int lat, input int inj);
    int cnt;
    @(negedge clk) start_port = 1;
    @(negedge clk) start_port = 0;
    cnt = 1;
    while (done_port !== 1'b1 && cnt < lat + 20) begin
      if (inj != 0 && cnt == inj) begin
        S_oe_ram = 2'b01; S_addr_ram = {7'd0, 7'(BASE)}; start_port = 1;
      end
      @(negedge clk); cnt++;
      if (inj != 0 && cnt == inj + 1) begin
        S_oe_ram = 0; start_port = 0;
        chk("busy_rdy", 64'(Sout_DataRdy), 64'd0);
      end
    end
    chk("latency", 64'(cnt), 64'(lat));
    @(negedge clk) chk("done_width", 64'(done_port), 64'd0);
  endtask

  initial begin
    int lat, pulses;
    reset = 0; start_port = 0; S_oe_ram = 0; S_we_ram = 0;
    S_addr_ram = 0; S_Wdata_ram = 0; S_data_ram_size = {7'd32, 7'd32};
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1;
    chk("rst_done", 64'(done_port), 64'd0);
    chk("rst_rdy", 64'(Sout_DataRdy), 64'd0);
    chk("rst_rdata", Sout_Rdata_ram[63:0] | Sout_Rdata_ram[127:64], 64'd0);

    // First start initialises then sorts.
    for (int i = 0; i < N; i++) mdl[i] = -(i+1);
    lat = N + sort_lat();
    chk("lat_init_formula", 64'(lat), 64'(N + N*(N-1) + (N-1) + 1));
    run_sort(lat, 0);
    model_sort();
    read_all();

    // Already sorted data.
    run_sort(sort_lat(), 0);
    read_all();

    // Host-written pattern with duplicates.
    for (int i = 0; i < N; i += 2) begin
      int v0, v1;
      v0 = (i == 0) ? 5 : (i == 2) ? 3 : (i == 4) ? 0 : ((i*7) % 13) - 6;
      v1 = (i == 0) ? 3 : (i == 2) ? -7 : ((i+1)*7 % 13) - 6;
      acc(2'b00, 2'b11, BASE + 4*i, BASE + 4*(i+1), v0, v1);
    end
    run_sort(sort_lat(), 0);
    model_sort();
    read_all();

    // Rejected host accesses leave RAM untouched.
    acc(2'b00, 2'b11, 28, BASE + 4*N, 77, 88);
    acc(2'b00, 2'b11, 34, BASE, 99, 66, 32, 16);
    acc(2'b11, 2'b00, 28, 34, 0, 0);
    read_all();

    // Same-address writes: lane 1 wins; read alongside a write sees old data.
    acc(2'b00, 2'b11, BASE + 4, BASE + 4, 111, 222);
    acc(2'b01, 2'b10, BASE + 8, BASE + 8, 0, 333);
    acc(2'b11, 2'b00, BASE + 4, BASE + 8, 0, 0);

    // Reset mid-sort: abort without done, re-init on next start.
    @(negedge clk) start_port = 1;
    @(negedge clk) start_port = 0;
    repeat (50) @(negedge clk);
    reset = 0;
    @(negedge clk) reset = 1;
    pulses = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (done_port === 1'b1) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'd0);
    for (int i = 0; i < N; i++) mdl[i] = -(i+1);
    run_sort(N + sort_lat(), 0);
    model_sort();
    read_all();

    // Host read and restart while busy are ignored.
    run_sort(sort_lat(), 10);
    read_all();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
